bnn_conv_multi: RTL and testbench

//  Parametrised binary (XNOR/popcount) KxK convolution engine. Streams a sequence of

---
 rtl/bnn_conv_multi_if.sv | 42 ++++
 rtl/bnn_conv_multi.sv | 271 +++++++++++++++++++++++++++
 tb/tb_bnn_conv_multi.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bnn_conv_multi_if.sv
// Bus bundle for bnn_conv_multi: run/status handshake, input and output image
// SRAM ports and the weight memory read port. The master side is the engine.
interface bnn_conv_multi_if #(
  parameter int ADDR_W = 12
) ();
  logic              dut_run;
  logic              dut_busy;
  logic              dut_err;
  logic [ADDR_W-1:0] dut_sram_read_address;
  logic [15:0]       sram_dut_read_data;
  logic [ADDR_W-1:0] dut_sram_write_address;
  logic [15:0]       dut_sram_write_data;
  logic              dut_sram_write_enable;
  logic [ADDR_W-1:0] dut_wmem_read_address;
  logic [15:0]       wmem_dut_read_data;

  modport master (
    input  dut_run,
    input  sram_dut_read_data,
    input  wmem_dut_read_data,
    output dut_busy,
    output dut_err,
    output dut_sram_read_address,
    output dut_sram_write_address,
    output dut_sram_write_data,
    output dut_sram_write_enable,
    output dut_wmem_read_address
  );

  modport slave (
    output dut_run,
    output sram_dut_read_data,
    output wmem_dut_read_data,
    input  dut_busy,
    input  dut_err,
    input  dut_sram_read_address,
    input  dut_sram_write_address,
    input  dut_sram_write_data,
    input  dut_sram_write_enable,
    input  dut_wmem_read_address
  );
endinterface

// File: rtl/bnn_conv_multi.sv
// Binary KxK convolution engine. Loads a threshold and NUM_FILTERS kernels from
// the weight memory, then streams square binary images from the input SRAM,
// emitting one thresholded XNOR/popcount row word per (output row, filter).
// Images with an edge outside K..MAX_DIM are skipped and flagged in dut_err.
// Every memory read takes three cycles: present address, memory registers the
// word, engine consumes it.
module bnn_conv_multi #(
  parameter int K           = 3,
  parameter int NUM_FILTERS = 2,
  parameter int MAX_DIM     = 16,
  parameter int ADDR_W      = 12
) (
  input logic             clk,
  input logic             reset_b,
  bnn_conv_multi_if.master bus
);

  localparam int KK  = K * K;
  localparam int MAJ = (KK + 1) / 2;
  localparam int FW  = $clog2(NUM_FILTERS + 1);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_LOAD_W  = 4'd1,
    S_RD_DIM  = 4'd2,
    S_SKIP    = 4'd3,
    S_FILL    = 4'd4,
    S_COMPUTE = 4'd5,
    S_WRITE   = 4'd6,
    S_DONE    = 4'd7
  } state_t;

  state_t                              state_r;
  logic [1:0]                          ph_r;
  logic                                busy_r;
  logic                                err_r;
  logic [ADDR_W-1:0]                   rd_addr_r;
  logic [ADDR_W-1:0]                   rd_ptr_r;
  logic [ADDR_W-1:0]                   wmem_addr_r;
  logic [ADDR_W-1:0]                   wr_addr_r;
  logic [ADDR_W-1:0]                   wr_ptr_r;
  logic [15:0]                         wr_data_r;
  logic                                wr_en_r;
  logic [4:0]                          thr_r;
  logic [NUM_FILTERS-1:0][KK-1:0]      kern_r;
  logic [K-1:0][15:0]                  rows_r;
  logic [NUM_FILTERS-1:0][15:0]        res_r;
  logic [7:0]                          dim_r;
  logic [7:0]                          out_row_r;
  logic [2:0]                          fill_cnt_r;
  logic [FW-1:0]                       filt_r;

  logic [4:0]                          thr_eff_s;
  logic [NUM_FILTERS-1:0][15:0]        conv_s;
  logic [15:0]                         res_sel_s;

  // One output column: count XNOR matches over the KxK window starting at
  // column col (row index 0 is the oldest row) and compare against thr.
  function automatic logic window_hit(
    input logic [KK-1:0]    kern,
    input logic [K-1:0][15:0] rows,
    input int               col,
    input logic [4:0]       thr
  );
    logic [4:0]  pc;
    logic [15:0] sh;
    pc = 5'd0;
    for (int j = 0; j < K; j++) begin
      sh = rows[j] >> col;
      for (int c = 0; c < K; c++) begin
        pc = pc + {4'b0000, ~(kern[j*K+c] ^ sh[c])};
      end
    end
    return (pc >= thr);
  endfunction

  // A zero threshold word selects majority voting.
  assign thr_eff_s = (thr_r == 5'd0) ? 5'(MAJ) : thr_r;

  // Full output row for every filter; columns beyond N-K stay zero.
  always_comb begin
    for (int f = 0; f < NUM_FILTERS; f++) begin
      conv_s[f] = 16'h0000;
      for (int i = 0; i <= MAX_DIM - K; i++) begin
        conv_s[f][i] = (8'(i + K) <= dim_r) && window_hit(kern_r[f], rows_r, i, thr_eff_s);
      end
    end
  end

  // Pick the buffered result of the filter currently being written.
  always_comb begin
    res_sel_s = 16'h0000;
    for (int f = 0; f < NUM_FILTERS; f++) begin
      res_sel_s = (filt_r == FW'(f)) ? res_r[f] : res_sel_s;
    end
  end

  // Control FSM with registered memory addresses, write strobe and status.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_r     <= S_IDLE;
      ph_r        <= 2'd0;
      busy_r      <= 1'b0;
      err_r       <= 1'b0;
      rd_addr_r   <= {ADDR_W{1'b0}};
      rd_ptr_r    <= {ADDR_W{1'b0}};
      wmem_addr_r <= {ADDR_W{1'b0}};
      wr_addr_r   <= {ADDR_W{1'b0}};
      wr_ptr_r    <= {ADDR_W{1'b0}};
      wr_data_r   <= 16'h0000;
      wr_en_r     <= 1'b0;
      thr_r       <= 5'd0;
      kern_r      <= '0;
      rows_r      <= '0;
      res_r       <= '0;
      dim_r       <= 8'd0;
      out_row_r   <= 8'd0;
      fill_cnt_r  <= 3'd0;
      filt_r      <= {FW{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          wr_en_r <= 1'b0;
          if (bus.dut_run) begin
            busy_r   <= 1'b1;
            err_r    <= 1'b0;
            rd_ptr_r <= {ADDR_W{1'b0}};
            wr_ptr_r <= {ADDR_W{1'b0}};
            filt_r   <= {FW{1'b0}};
            ph_r     <= 2'd0;
            state_r  <= S_LOAD_W;
          end
        end

        // Word 0 is the threshold, words 1..NUM_FILTERS the kernels.
        S_LOAD_W: begin
          case (ph_r)
            2'd0: begin
              wmem_addr_r <= ADDR_W'(filt_r);
              ph_r        <= 2'd1;
            end
            2'd1: ph_r <= 2'd2;
            default: begin
              ph_r <= 2'd0;
              if (filt_r == {FW{1'b0}}) begin
                thr_r <= bus.wmem_dut_read_data[4:0];
              end
              for (int f = 0; f < NUM_FILTERS; f++) begin
                if (filt_r == FW'(f + 1)) begin
                  kern_r[f] <= bus.wmem_dut_read_data[KK-1:0];
                end
              end
              if (filt_r == FW'(NUM_FILTERS)) begin
                filt_r  <= {FW{1'b0}};
                state_r <= S_RD_DIM;
              end else begin
                filt_r <= filt_r + FW'(1);
              end
            end
          endcase
        end

        // Fetch and classify the next dimension word.
        S_RD_DIM: begin
          case (ph_r)
            2'd0: begin
              rd_addr_r <= rd_ptr_r;
              ph_r      <= 2'd1;
            end
            2'd1: ph_r <= 2'd2;
            default: begin
              ph_r  <= 2'd0;
              dim_r <= bus.sram_dut_read_data[7:0];
              if (bus.sram_dut_read_data[7:0] == 8'hFF) begin
                state_r <= S_DONE;
              end else if ((bus.sram_dut_read_data[7:0] < 8'(K)) ||
                           (bus.sram_dut_read_data[7:0] > 8'(MAX_DIM))) begin
                err_r   <= 1'b1;
                state_r <= S_SKIP;
              end else begin
                rd_ptr_r   <= rd_ptr_r + ADDR_W'(1);
                fill_cnt_r <= 3'd0;
                out_row_r  <= 8'd0;
                state_r    <= S_FILL;
              end
            end
          endcase
        end

        // Jump over the dimension word and all rows of the rejected image.
        S_SKIP: begin
          rd_ptr_r <= rd_ptr_r + ADDR_W'(dim_r) + ADDR_W'(1);
          state_r  <= S_RD_DIM;
        end

        // Shift rows into the window; a slide enters with fill_cnt at K-1.
        S_FILL: begin
          case (ph_r)
            2'd0: begin
              rd_addr_r <= rd_ptr_r;
              ph_r      <= 2'd1;
            end
            2'd1: ph_r <= 2'd2;
            default: begin
              ph_r     <= 2'd0;
              rows_r   <= {bus.sram_dut_read_data, rows_r[K-1:1]};
              rd_ptr_r <= rd_ptr_r + ADDR_W'(1);
              if (fill_cnt_r == 3'(K - 1)) begin
                state_r <= S_COMPUTE;
              end else begin
                fill_cnt_r <= fill_cnt_r + 3'd1;
              end
            end
          endcase
        end

        // Latch all filter results and issue the filter-0 write so that the
        // strobe is high only while the FSM sits in WRITE.
        S_COMPUTE: begin
          res_r     <= conv_s;
          wr_en_r   <= 1'b1;
          wr_data_r <= conv_s[0];
          wr_addr_r <= wr_ptr_r;
          wr_ptr_r  <= wr_ptr_r + ADDR_W'(1);
          filt_r    <= FW'(1);
          state_r   <= S_WRITE;
        end

        S_WRITE: begin
          if (filt_r == FW'(NUM_FILTERS)) begin
            wr_en_r <= 1'b0;
            filt_r  <= {FW{1'b0}};
            if (out_row_r == (dim_r - 8'(K))) begin
              state_r <= S_RD_DIM;
            end else begin
              out_row_r  <= out_row_r + 8'd1;
              fill_cnt_r <= 3'(K - 1);
              state_r    <= S_FILL;
            end
          end else begin
            wr_en_r   <= 1'b1;
            wr_data_r <= res_sel_s;
            wr_addr_r <= wr_ptr_r;
            wr_ptr_r  <= wr_ptr_r + ADDR_W'(1);
            filt_r    <= filt_r + FW'(1);
          end
        end

        S_DONE: begin
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end

        default: begin
          wr_en_r <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.dut_busy               = busy_r;
  assign bus.dut_err                = err_r;
  assign bus.dut_sram_read_address  = rd_addr_r;
  assign bus.dut_wmem_read_address  = wmem_addr_r;
  assign bus.dut_sram_write_address = wr_addr_r;
  assign bus.dut_sram_write_data    = wr_data_r;
  assign bus.dut_sram_write_enable  = wr_en_r;

endmodule

// File: tb/tb_bnn_conv_multi.sv
// Directed bench for bnn_conv_multi (K=3, two filters, 16-wide images).
module tb_bnn_conv_multi;
  localparam int ADDR_W = 12;

  logic clk = 1'b0;
  logic reset_b = 1'b1;
  always #5 clk = ~clk;

  bnn_conv_multi_if #(.ADDR_W(ADDR_W)) bus ();

  bnn_conv_multi #(.K(3), .NUM_FILTERS(2), .MAX_DIM(16), .ADDR_W(ADDR_W)) dut (
    .clk(clk),
    .reset_b(reset_b),
    .bus(bus)
  );

  logic [15:0] imem [256];
  logic [15:0] wmem [16];

  // Synchronous memories: data one cycle after the address.
  always @(posedge clk) begin
    bus.sram_dut_read_data <= imem[bus.dut_sram_read_address[7:0]];
    bus.wmem_dut_read_data <= wmem[bus.dut_wmem_read_address[3:0]];
  end

  int          cap_n = 0;
  logic [11:0] cap_addr [512];
  logic [15:0] cap_data [512];

  // Log every write beat, sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.dut_sram_write_enable === 1'b1) begin
      if (cap_n < 512) begin
        cap_addr[cap_n] = bus.dut_sram_write_address;
        cap_data[cap_n] = bus.dut_sram_write_data;
      end
      cap_n = cap_n + 1;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
    for (int i = 0; i < 16; i++) wmem[i] = 16'h0000;
  endtask

  task automatic put_img(input int p, input logic [15:0] dimw, input int n,
                         input logic [15:0] rowv, output int pn);
    imem[p] = dimw;
    for (int i = 0; i < n; i++) imem[p + 1 + i] = rowv;
    pn = p + 1 + n;
  endtask

  task automatic load_test1();
    int p;
    clear_mem();
    wmem[0] = 16'h0000;
    wmem[1] = 16'h01FF;
    wmem[2] = 16'h0000;
    put_img(0, 16'h000A, 10, 16'h03FF, p);
    imem[p] = 16'h00FF;
  endtask

  // Pulse dut_run for one cycle and wait (bounded) for busy to drop.
  task automatic run_dut(input int budget, output logic busy_first, output bit done, output int cycles);
    @(negedge clk);
    bus.dut_run = 1'b1;
    @(negedge clk);
    bus.dut_run = 1'b0;
    busy_first = bus.dut_busy;
    done = 1'b0;
    cycles = 0;
    for (int n = 0; n < budget; n++) begin
      if (bus.dut_busy === 1'b0) begin
        done = 1'b1;
        break;
      end
      cycles = cycles + 1;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #2 reset_b = 1'b0;
    #1;
    n_tests++;
    if ({bus.dut_busy, bus.dut_err, bus.dut_sram_write_enable} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_status: got %b, expected 000", {bus.dut_busy, bus.dut_err, bus.dut_sram_write_enable});
    end
    n_tests++;
    if ({bus.dut_sram_read_address, bus.dut_sram_write_address, bus.dut_wmem_read_address, bus.dut_sram_write_data} !== 52'h0) begin
      n_fail++;
      $display("FAIL reset_bus: got %h, expected 0", {bus.dut_sram_read_address, bus.dut_sram_write_address, bus.dut_wmem_read_address, bus.dut_sram_write_data});
    end
    repeat (2) @(negedge clk);
    reset_b = 1'b1;
  endtask

  task automatic test_single_image();
    int base, cyc;
    logic bf;
    bit done;
    logic [15:0] exp;
    load_test1();
    base = cap_n;
    run_dut(2000, bf, done, cyc);
    n_tests++;
    if (bf !== 1'b1) begin n_fail++; $display("FAIL t1_busy_rise: got %b, expected 1", bf); end
    n_tests++;
    if (!done) begin n_fail++; $display("FAIL t1_timeout: got busy, expected idle"); end
    n_tests++;
    if (cap_n - base !== 16) begin n_fail++; $display("FAIL t1_count: got %0d, expected 16", cap_n - base); end
    for (int k = 0; k < 16; k++) begin
      exp = (k % 2 == 0) ? 16'h00FF : 16'h0000;
      n_tests++;
      if (cap_addr[base+k] !== 12'(k) || cap_data[base+k] !== exp) begin
        n_fail++;
        $display("FAIL t1_write%0d: got %h/%h, expected %h/%h", k, cap_addr[base+k], cap_data[base+k], 12'(k), exp);
      end
    end
    n_tests++;
    if (bus.dut_err !== 1'b0) begin n_fail++; $display("FAIL t1_err: got %b, expected 0", bus.dut_err); end
  endtask

  task automatic test_empty_run();
    int base, cyc;
    logic bf;
    bit done;
    clear_mem();
    imem[0] = 16'h00FF;
    base = cap_n;
    run_dut(200, bf, done, cyc);
    n_tests++;
    if (!done || cyc >= 20) begin n_fail++; $display("FAIL t2_busy_len: got %0d cycles, expected under 20", cyc); end
    n_tests++;
    if (cap_n - base !== 0) begin n_fail++; $display("FAIL t2_count: got %0d, expected 0", cap_n - base); end
    n_tests++;
    if (bus.dut_err !== 1'b0) begin n_fail++; $display("FAIL t2_err: got %b, expected 0", bus.dut_err); end
  endtask

  task automatic test_skip();
    int base, cyc, p;
    logic bf;
    bit done;
    logic [15:0] exp;
    load_test1();
    put_img(0, 16'h0010, 16, 16'hFFFF, p);
    put_img(p, 16'h0002, 2, 16'hFFFF, p);
    put_img(p, 16'h0005, 5, 16'h001F, p);
    imem[p] = 16'h00FF;
    base = cap_n;
    run_dut(4000, bf, done, cyc);
    n_tests++;
    if (!done) begin n_fail++; $display("FAIL t3_timeout: got busy, expected idle"); end
    n_tests++;
    if (cap_n - base !== 34) begin n_fail++; $display("FAIL t3_count: got %0d, expected 34", cap_n - base); end
    for (int k = 0; k < 34; k++) begin
      if (k < 28) exp = (k % 2 == 0) ? 16'h3FFF : 16'h0000;
      else        exp = (k % 2 == 0) ? 16'h0007 : 16'h0000;
      n_tests++;
      if (cap_addr[base+k] !== 12'(k) || cap_data[base+k] !== exp) begin
        n_fail++;
        $display("FAIL t3_write%0d: got %h/%h, expected %h/%h", k, cap_addr[base+k], cap_data[base+k], 12'(k), exp);
      end
    end
    n_tests++;
    if (bus.dut_err !== 1'b1) begin n_fail++; $display("FAIL t3_err: got %b, expected 1", bus.dut_err); end
  endtask

  task automatic test_single_zero();
    int base, cyc;
    logic bf;
    bit done;
    logic [15:0] exp;
    load_test1();
    wmem[0] = 16'h0009;
    imem[5] = 16'h03EF;
    base = cap_n;
    run_dut(2000, bf, done, cyc);
    n_tests++;
    if (!done || cap_n - base !== 16) begin n_fail++; $display("FAIL t4_count: got %0d, expected 16", cap_n - base); end
    for (int k = 0; k < 16; k++) begin
      if (k % 2 == 1) exp = 16'h0000;
      else if (k / 2 >= 2 && k / 2 <= 4) exp = 16'h00E3;
      else exp = 16'h00FF;
      n_tests++;
      if (cap_data[base+k] !== exp) begin
        n_fail++;
        $display("FAIL t4_write%0d: got %h, expected %h", k, cap_data[base+k], exp);
      end
    end
    n_tests++;
    if (bus.dut_err !== 1'b0) begin n_fail++; $display("FAIL t4_err_cleared: got %b, expected 0", bus.dut_err); end
  endtask

  task automatic test_orientation();
    int base, cyc, p;
    logic bf;
    bit done;
    logic [15:0] exp [10];
    clear_mem();
    wmem[0] = 16'h0029;
    wmem[1] = 16'hFE07;
    wmem[2] = 16'hFE49;
    put_img(0, 16'hAB04, 4, 16'h0000, p);
    imem[1] = 16'h000F;
    put_img(p, 16'h0005, 5, 16'h0001, p);
    imem[p] = 16'h00FF;
    exp = '{16'h0003, 16'h0000, 16'h0000, 16'h0000,
            16'h0000, 16'h0001, 16'h0000, 16'h0001, 16'h0000, 16'h0001};
    base = cap_n;
    run_dut(2000, bf, done, cyc);
    n_tests++;
    if (!done || cap_n - base !== 10) begin n_fail++; $display("FAIL t_orient_count: got %0d, expected 10", cap_n - base); end
    for (int k = 0; k < 10; k++) begin
      n_tests++;
      if (cap_addr[base+k] !== 12'(k) || cap_data[base+k] !== exp[k]) begin
        n_fail++;
        $display("FAIL t_orient_write%0d: got %h/%h, expected %h/%h", k, cap_addr[base+k], cap_data[base+k], 12'(k), exp[k]);
      end
    end
  endtask

  task automatic test_thr_over();
    int base, cyc;
    logic bf;
    bit done;
    load_test1();
    wmem[0] = 16'h000A;
    base = cap_n;
    run_dut(2000, bf, done, cyc);
    n_tests++;
    if (!done || cap_n - base !== 16) begin n_fail++; $display("FAIL t_thr_count: got %0d, expected 16", cap_n - base); end
    for (int k = 0; k < 16; k++) begin
      n_tests++;
      if (cap_data[base+k] !== 16'h0000) begin
        n_fail++;
        $display("FAIL t_thr_write%0d: got %h, expected 0000", k, cap_data[base+k]);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    int base, cyc;
    logic bf;
    bit done, hit;
    logic [15:0] exp;
    load_test1();
    @(negedge clk);
    bus.dut_run = 1'b1;
    @(negedge clk);
    bus.dut_run = 1'b0;
    hit = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (bus.dut_sram_write_enable === 1'b1) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_tests++;
    if (!hit) begin n_fail++; $display("FAIL t5_no_write: got none, expected a write beat"); end
    #1 reset_b = 1'b0;
    #1;
    n_tests++;
    if ({bus.dut_busy, bus.dut_err, bus.dut_sram_write_enable} !== 3'b000 ||
        {bus.dut_sram_read_address, bus.dut_sram_write_address, bus.dut_wmem_read_address, bus.dut_sram_write_data} !== 52'h0) begin
      n_fail++;
      $display("FAIL t5_reset_outputs: got %b/%h, expected 000/0", {bus.dut_busy, bus.dut_err, bus.dut_sram_write_enable},
               {bus.dut_sram_read_address, bus.dut_sram_write_address, bus.dut_wmem_read_address, bus.dut_sram_write_data});
    end
    @(negedge clk);
    reset_b = 1'b1;
    base = cap_n;
    run_dut(2000, bf, done, cyc);
    n_tests++;
    if (!done || cap_n - base !== 16) begin n_fail++; $display("FAIL t5_count: got %0d, expected 16", cap_n - base); end
    for (int k = 0; k < 16; k++) begin
      exp = (k % 2 == 0) ? 16'h00FF : 16'h0000;
      n_tests++;
      if (cap_addr[base+k] !== 12'(k) || cap_data[base+k] !== exp) begin
        n_fail++;
        $display("FAIL t5_write%0d: got %h/%h, expected %h/%h", k, cap_addr[base+k], cap_data[base+k], 12'(k), exp);
      end
    end
  endtask

  task automatic test_run_while_busy();
    int base;
    bit done;
    logic [15:0] exp;
    load_test1();
    base = cap_n;
    @(negedge clk);
    bus.dut_run = 1'b1;
    @(negedge clk);
    bus.dut_run = 1'b0;
    done = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      if (n == 20 || n == 60) bus.dut_run = 1'b1;
      else bus.dut_run = 1'b0;
      if (bus.dut_busy === 1'b0) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    bus.dut_run = 1'b0;
    repeat (10) @(negedge clk);
    n_tests++;
    if (!done || bus.dut_busy !== 1'b0) begin n_fail++; $display("FAIL t6_restart: got busy %b, expected 0", bus.dut_busy); end
    n_tests++;
    if (cap_n - base !== 16) begin n_fail++; $display("FAIL t6_count: got %0d, expected 16", cap_n - base); end
    for (int k = 0; k < 16; k++) begin
      exp = (k % 2 == 0) ? 16'h00FF : 16'h0000;
      n_tests++;
      if (cap_addr[base+k] !== 12'(k) || cap_data[base+k] !== exp) begin
        n_fail++;
        $display("FAIL t6_write%0d: got %h/%h, expected %h/%h", k, cap_addr[base+k], cap_data[base+k], 12'(k), exp);
      end
    end
  endtask

  initial begin
    bus.dut_run = 1'b0;
    clear_mem();
    test_reset();
    test_single_image();
    test_empty_run();
    test_skip();
    test_single_zero();
    test_orientation();
    test_thr_over();
    test_reset_mid_write();
    test_run_while_busy();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
